// File: rtl/max7219_display_driver.sv
// Serial transmitter for a MAX7219 8-digit LED driver: sends a fixed init
// sequence after reset, then one eight-word digit frame per update request.
module max7219_display_driver #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [3:0]  INTENSITY  = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT = 3'd7
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_update_stb,
    input  logic [63:0] i_digits,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_next;
    logic [7:0]  div_cnt;
    logic        half;
    logic [4:0]  bit_cnt;
    logic [2:0]  word_idx;
    logic        pending;
    logic [63:0] frame_buf;

    logic        div_tick, word_end, last_word, start_frame, sending;
    logic [15:0] cur_word;
    logic        dout_d, sclk_d, load_d, busy_d, done_d;

    // Request handshake: i_update_stb is a one-cycle request that is never
    // refused. In IDLE it starts a frame at once; otherwise it sets a single
    // pending flag (repeats coalesce). o_busy is low only when IDLE with
    // nothing pending, so an upstream may strobe whenever o_busy is low.
    always_comb begin
        cur_word = 16'h0000;
        case (state)
            ST_INIT: begin
                case (word_idx)
                    3'd0:    cur_word = 16'h0F00;
                    3'd1:    cur_word = 16'h0900;
                    3'd2:    cur_word = {8'h0B, 5'd0, SCAN_LIMIT};
                    3'd3:    cur_word = {8'h0A, 4'd0, INTENSITY};
                    default: cur_word = 16'h0C01;
                endcase
            end
            ST_FRAME: cur_word = {4'h0, {1'b0, word_idx} + 4'd1,
                                  frame_buf[{word_idx, 3'b000} +: 8]};
            default:  cur_word = 16'h0000;
        endcase
    end

    always_comb begin
        div_tick    = (div_cnt == DIV_LAST);
        word_end    = div_tick && half && (bit_cnt == 5'd16);
        last_word   = (state == ST_INIT) ? (word_idx == 3'd4) : (word_idx == 3'd7);
        start_frame = (state == ST_IDLE) && (pending || i_update_stb);
        sending     = (state != ST_IDLE);

        state_next = state;
        case (state)
            ST_INIT:  if (word_end && last_word) state_next = ST_IDLE;
            ST_IDLE:  if (start_frame) state_next = ST_FRAME;
            ST_FRAME: if (word_end && last_word) state_next = ST_IDLE;
            default:  state_next = ST_INIT;
        endcase

        // Slots 0..15 carry bits 15..0; slot 16 is load (first half) then gap.
        dout_d = sending && !bit_cnt[4] && cur_word[~bit_cnt[3:0]];
        sclk_d = sending && !bit_cnt[4] && half;
        load_d = sending && bit_cnt[4] && !half;
        busy_d = sending || pending || i_update_stb;
        done_d = (state == ST_FRAME) && word_end && last_word;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_INIT;
        else         state <= state_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt   <= 8'd0;
            half      <= 1'b0;
            bit_cnt   <= 5'd0;
            word_idx  <= 3'd0;
            pending   <= 1'b0;
            frame_buf <= 64'd0;
        end else begin
            if (!sending) begin
                div_cnt  <= 8'd0;
                half     <= 1'b0;
                bit_cnt  <= 5'd0;
                word_idx <= 3'd0;
                if (start_frame) frame_buf <= i_digits;
            end else if (div_tick) begin
                div_cnt <= 8'd0;
                half    <= ~half;
                if (half) begin
                    if (bit_cnt == 5'd16) begin
                        bit_cnt  <= 5'd0;
                        word_idx <= last_word ? 3'd0 : word_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (start_frame)       pending <= 1'b0;
            else if (i_update_stb) pending <= 1'b1;
        end
    end

    // Registered outputs so reset forces every pin low without a load edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_serial_dout <= 1'b0;
            o_serial_clk  <= 1'b0;
            o_serial_load <= 1'b0;
        end else begin
            o_busy        <= busy_d;
            o_frame_done  <= done_d;
            o_serial_dout <= dout_d;
            o_serial_clk  <= sclk_d;
            o_serial_load <= load_d;
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_max7219_display_driver.sv
// Self-checking bench for max7219_display_driver: mock serial receiver feeding
// a scoreboard, plus pin-timing and frame-latency checks.
module tb_max7219_display_driver;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_update_stb = 1'b0;
  logic [63:0] i_digits = '0;
  logic        o_busy, o_frame_done, o_serial_dout, o_serial_clk, o_serial_load;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int scyc = 0;
  int busy_low_cnt = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  logic [7:0] mock_dig [8];

  // monitor history
  logic        p_clk = 1'b0, p_load = 1'b0, p_dout = 1'b0, pp_dout = 1'b0;
  int          hi_len = 0, ld_len = 0, seq_pos = 0, seq_len = 5, last_load = 0, rx_idx = 0;
  logic [15:0] shift = '0;

  localparam logic [63:0] DIG_A  = 64'h705F5B33796D307E;
  localparam logic [63:0] DIG_E  = 64'h1122334455ED6677;
  localparam logic [63:0] DIG_D  = 64'h0102040810204080;
  localparam logic [63:0] DIG_A2 = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] DIG_B  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] DIG_C  = 64'h8899AABBCCDDEEFF;

  // clock / reset
  always #50 i_clk = ~i_clk;

  max7219_display_driver #(.CLK_DIV(2), .INTENSITY(4'h8), .SCAN_LIMIT(3'd7)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_update_stb(i_update_stb),
    .i_digits(i_digits),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_serial_dout(o_serial_dout),
    .o_serial_clk(o_serial_clk),
    .o_serial_load(o_serial_load),
    .o_dbg_state(o_dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, scyc);
    end
  endtask

  function automatic int seg2num(input logic [7:0] s);
    case (s[6:0])
      7'h7E: return 0;
      7'h30: return 1;
      7'h6D: return 2;
      7'h79: return 3;
      7'h33: return 4;
      7'h5B: return 5;
      7'h5F: return 6;
      7'h70: return 7;
      7'h7F: return 8;
      7'h7B: return 9;
      default: return 15;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic strobe();
    i_update_stb = 1'b1;
    tick();
    i_update_stb = 1'b0;
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic push_frame(input logic [63:0] d);
    for (int i = 0; i < 8; i++) exp_q.push_back({4'h0, 4'(i + 1), d[8*i +: 8]});
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (o_frame_done) begin
        at = scyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame_done within 2000 cycles", name);
    end
  endtask

  // monitor: mock receiver + scoreboard pop + pin timing
  initial begin
    forever begin
      @(negedge i_clk);
      scyc++;
      if (i_reset) begin
        p_clk = 1'b0; p_load = 1'b0; p_dout = 1'b0; pp_dout = 1'b0;
        hi_len = 0; ld_len = 0; seq_pos = 0; seq_len = 5;
        continue;
      end
      if (!o_busy) busy_low_cnt++;
      if (o_frame_done) done_cnt++;

      if (o_serial_clk && !p_clk) begin
        check("dout_setup", {o_serial_dout, p_dout}, {pp_dout, pp_dout});
        shift = {shift[14:0], o_serial_dout};
        hi_len = 1;
      end else if (o_serial_clk) begin
        hi_len++;
        check("dout_hold", o_serial_dout, p_dout);
      end else if (p_clk) begin
        check("clk_high_len", hi_len, 2);
      end

      if (o_serial_load) begin
        check("load_quiet", {o_serial_dout, o_serial_clk}, 0);
        if (!p_load) begin
          ld_len = 1;
          rx_cnt++;
          if (seq_pos != 0) check("word_period", scyc - last_load, 68);
          last_load = scyc;
          seq_pos++;
          if (seq_pos == seq_len) begin
            seq_pos = 0;
            seq_len = 8;
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_word: got 0x%0h, nothing expected (cycle %0d)", shift, scyc);
          end else begin
            check("rx_word", shift, exp_q.pop_front());
          end
          rx_idx = int'(shift[11:8]);
          if (shift[15:12] == 4'h0 && rx_idx >= 1 && rx_idx <= 8) mock_dig[rx_idx - 1] = shift[7:0];
        end else begin
          ld_len++;
        end
      end else if (p_load) begin
        check("load_high_len", ld_len, 2);
      end

      pp_dout = p_dout;
      p_dout  = o_serial_dout;
      p_clk   = o_serial_clk;
      p_load  = o_serial_load;
    end
  end

  // stimulus
  initial begin
    int at, b, rel, d1;

    // reset and init sequence
    repeat (3) tick();
    check("reset_outputs", {o_busy, o_frame_done, o_serial_dout, o_serial_clk, o_serial_load, o_dbg_state}, 0);
    push_init();
    rel = scyc;
    i_reset = 1'b0;
    tick();
    check("busy_after_release", o_busy, 1);
    at = -1;
    for (int n = 0; n < 1000; n++) begin
      if (!o_busy) begin
        at = scyc - rel;
        break;
      end
      tick();
    end
    check("init_busy_low_cycle", at, 341);
    check("init_rx_words", rx_cnt, 5);
    check("init_no_done", done_cnt, 0);
    check("idle_state", o_dbg_state, 1);

    // single frame
    i_digits = DIG_A;
    push_frame(DIG_A);
    strobe();
    b = scyc;
    check("frame_busy_rise", o_busy, 1);
    wait_done("frame1", at);
    check("frame_latency", at - b, 544);
    tick();
    check("busy_after_frame", o_busy, 0);
    for (int i = 0; i < 8; i++) check("bcd_digit", seg2num(mock_dig[i]), i);

    // reset during bit 7 of digit word 2 (DP set, so dout is high)
    i_digits = DIG_E;
    push_frame(DIG_E);
    strobe();
    b = scyc;
    repeat (171) tick();
    check("pre_reset_active", {o_busy, o_serial_dout, o_serial_clk}, 3'b111);
    #10 i_reset = 1'b1;
    #1;
    check("reset_mid_word", {o_busy, o_frame_done, o_serial_dout, o_serial_clk, o_serial_load, o_dbg_state}, 0);
    exp_q.delete();
    push_init();
    tick();
    tick();
    rel = scyc;
    i_reset = 1'b0;
    tick();
    busy_low_cnt = 0;

    // strobe during init is queued until init completes
    repeat (99) tick();
    i_digits = DIG_D;
    push_frame(DIG_D);
    strobe();
    wait_done("init_queued_frame", at);
    check("init_queued_latency", at - rel, 885);
    check("init_queued_busy_gap", busy_low_cnt, 0);
    tick();
    check("idle_after_queued", o_busy, 0);

    // coalescing: two strobes mid-frame, digits change twice
    i_digits = DIG_A2;
    push_frame(DIG_A2);
    strobe();
    b = scyc;
    busy_low_cnt = 0;
    repeat (200) tick();
    strobe();
    i_digits = DIG_B;
    repeat (50) tick();
    i_digits = DIG_C;
    push_frame(DIG_C);
    strobe();
    wait_done("coalesce_f1", at);
    check("coalesce_f1_latency", at - b, 544);
    d1 = at;
    wait_done("coalesce_f2", at);
    check("coalesce_gap", at - d1, 545);
    check("coalesce_busy_gap", busy_low_cnt, 0);
    tick();
    check("coalesce_single_extra", o_busy, 0);

    // final report
    repeat (20) tick();
    check("done_count", done_cnt, 4);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/max7219_display_driver.md
Name: max7219_display_driver

Overview:
Serial transmitter for the MAX7219 8-digit LED driver interface; it is the sending end of the link that the display mock receives (serial data, serial clock, load).
- After reset it sends a fixed configuration sequence.
- On each update strobe it sends one frame of eight digit-register writes carrying raw segment bytes.
- It sits between the clock/display formatting logic and the uio_out serial pins: load = uio_out[0], dout = uio_out[1], clk = uio_out[3].

Parameters:
CLK_DIV, 2, system clocks per serial-clock half period; legal range 1..255.
INTENSITY, 4'h8, value sent to the intensity register (0x0A).
SCAN_LIMIT, 3'd7, value sent to the scan-limit register (0x0B).

Ports:
i_clk  input  1  system clock (~10 MHz).
i_reset  input  1  asynchronous, active-high reset.
i_update_stb  input  1  one-cycle request to send a digit frame.
i_digits  input  64  raw segment bytes; digit n is at [8n+7:8n]; bit7 = DP, bits[6:0] = segments A..G.
o_busy  output  1  high while any word is in flight or a request is pending.
o_frame_done  output  1  one-cycle pulse at the end of each digit frame.
o_serial_dout  output  1  serial data, MSB first.
o_serial_clk  output  1  serial clock; the receiver samples on the rising edge.
o_serial_load  output  1  latch strobe; the receiver latches the word on the rising edge.

Behaviour:
Reset (asynchronous, immediate, including mid-word):
- All outputs are 0. No load rising edge may be produced by reset.
- Pending flag is cleared; the sequencer returns to INIT word 0.
- After reset deasserts, the INIT sequence restarts from word 0.

State machine: INIT -> IDLE -> FRAME -> IDLE.
- INIT sends five words in order: 0x0F00 (display test off), 0x0900 (no decode), 0x0B00|SCAN_LIMIT, 0x0A00|INTENSITY, 0x0C01 (normal operation).
- No o_frame_done pulse for INIT.
- IDLE: if pending or i_update_stb, latch i_digits into a frame buffer, clear pending, and enter FRAME on the next cycle.
- FRAME sends 0x0100|d0, 0x0200|d1, ..., 0x0800|d7 in that order, then returns to IDLE.

Word timing (W = CLK_DIV), 34W cycles per word:
- Bit k (k = 15..0) occupies 2W cycles. o_serial_dout = word[k] for the whole slot. o_serial_clk is low for the first W cycles and high for the last W.
- After bit 0: o_serial_clk = 0, o_serial_load = 1 for W cycles, then load = 0 for W gap cycles.
- During the load and gap cycles, o_serial_dout = 0.
- The next word starts immediately after the gap. dout is stable from W cycles before each rising clock edge until the end of that slot.
- With CLK_DIV = 2: 68 cycles per word, 544 per frame, 340 for INIT.

o_busy:
- High from the cycle after reset release through INIT.
- High from the cycle after a strobe is accepted until the cycle after o_frame_done, with no gap if another request is pending.
- Low only in IDLE with no pending request.

o_frame_done: one-cycle pulse in the last gap cycle of word 8.

Request handling:
- i_update_stb during INIT or FRAME sets pending. Further strobes while pending is set coalesce; at most one request is queued.
- Digits are sampled when a frame starts, not when the strobe arrives. A frame in flight is never altered by changes to i_digits.
- i_update_stb in the same cycle a frame ends: the request is taken as pending and the next frame starts in the following cycle.

Counters:
- Divider counter is 8 bits.
- Bit counter 0..16 (16 = load phase).
- Word index 0..7. INIT index 0..4 is shared with the word index.

Test Plan:
- Reset release, CLK_DIV=2 -> mock receives 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01; exactly 5 load rising edges; o_busy low at cycle 341; no o_frame_done.
- Strobe with digits 0x7E,0x30,0x6D,0x79,0x33,0x5B,0x5F,0x70 -> mock digit0..7 equal these bytes; BCD view reads 0,1,2,3,4,5,6,7; o_frame_done 544 cycles after busy rises.
- Timing check -> serial_clk high exactly 2 cycles; dout unchanged 2 cycles before and during each rising edge; load high 2 cycles, followed by a 2-cycle gap; word period 68 cycles.
- Strobe mid-frame, then i_digits changes, then a second strobe -> first frame carries the old data; exactly one extra frame follows back-to-back with the newest digits; busy stays high between frames.
- Strobe during INIT -> digit frame starts the cycle after INIT word 5 completes.
- Assert i_reset during bit 7 of a digit word -> all outputs 0 in the same cycle; no load edge; after release the INIT sequence is seen again from 0x0F00.
